adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin scheduler that shares one registered 4-bit adder (`adder4b`-style: registered sum, load on enable, async reset) among N_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake and sequences the adder's enable. It captures the sum and returns it, tagged with the requester index, over a valid/ready response channel. It sits between the requester blocks and the single adder instance, which it drives through dedicated `add_*` ports.

## Interface
- `N_REQ`, default 4: number of requesters; range 2..8.
- `W`, default 4: operand width; the sum is W+1 bits.
- `IDW`, default 2: requester-index width, $clog2(N_REQ).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  N_REQ*W  packed operand A; requester i occupies bits [i*W +: W].
- `req_b`  in  N_REQ*W  packed operand B; same packing.
- `add_a`  out  W  operand A to the shared adder.
- `add_b`  out  W  operand B to the shared adder.
- `add_en`  out  1  adder load enable.
- `add_sum`  in  W+1  registered adder output.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_sum`  out  W+1  result.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_sum`.

## Operation
- **FSM states:**
  - IDLE: `req_ready` is combinational and high only for the grant winner; the operands of the winner are latched into `add_a`/`add_b`, and `gnt_id` is registered. On any `req_valid` the FSM moves to ISSUE; otherwise it stays in IDLE.
  - ISSUE: `add_en`=1 for exactly this cycle; next state is CAPTURE.
  - CAPTURE: `add_sum` is registered into `rsp_sum` and `gnt_id` into `rsp_id`; next state is RESP.
  - RESP: `rsp_valid`=1. On `rsp_valid & rsp_ready` the next state is IDLE; otherwise RESP holds.
- **Arbitration:**
  - Round-robin scheme: the search starts at `last_gnt+1` (mod N_REQ), and the first asserted `req_valid` wins.
  - `last_gnt` updates to the winner on acceptance.
  - `last_gnt` resets to N_REQ-1, so requester 0 has first priority after reset.
- **Requester rules:** once `req_valid` is raised, it and the operands stay stable until `req_ready` is seen. `req_ready` is only ever asserted in IDLE.
- **Response rules:** `rsp_sum` and `rsp_id` stay stable while `rsp_valid` is high and `rsp_ready` is low.
- **Arithmetic:** sum = A + B, zero-extended to W+1 bits. No overflow is possible (maximum 2^(W+1)-2). The block never alters `add_sum`.
- **Operand outputs:** `add_a` and `add_b` are registered and hold their last value outside ISSUE. Only `add_en` qualifies them.
- **Reset:** asserting `rst` at any point returns the FSM to IDLE and drops any in-flight request with no response. All outputs go to 0: `req_ready`, `add_a`, `add_b`, `add_en`, `rsp_valid`, `rsp_sum` and `rsp_id`.
- **Adder reset:** the shared adder takes the same `rst`.
- **Reserved encodings:** any illegal state encoding recovers to IDLE on the next clock edge.

## Timing
- **Accept:** occurs at edge T0 (IDLE, `req_valid[i] & req_ready[i]`).
- **Adder load:** `add_en` is high during cycle T0+1, and the adder loads at the end of that cycle.
- **Capture:** `add_sum` is valid in cycle T0+2 and is captured at the end of it.
- **Response:** `rsp_valid` first goes high in cycle T0+3.
- **Latency:** 3 cycles from accept to `rsp_valid`.
- **Throughput:** at best one operation per 4 cycles (RESP with `rsp_ready`=1, then IDLE).
- **Request visibility:** requests arriving during ISSUE, CAPTURE or RESP wait, and are seen in the next IDLE cycle.
- **Simultaneous requests:** exactly one is granted per IDLE cycle; the others keep `req_valid` high.
- **No bypass:** the response handshake and a new acceptance never occur in the same cycle.

## Test plan
- **Reset values:** hold `rst` for 2 cycles, then release with no requests. All outputs stay 0, the FSM stays in IDLE, and `add_en` never pulses.
- **Single request:** requester 2 sends A=3, B=5 with `rsp_ready`=1.
  - `req_ready`=4'b0100 in the accept cycle.
  - `add_en` pulses once, one cycle later.
  - `rsp_valid` is high 3 cycles after accept with `rsp_sum`=8 and `rsp_id`=2.
- **Full contention:** all four requesters hold `req_valid`, with operands i+i.
  - Grants arrive in order 0,1,2,3,0, one every 4 cycles.
  - Responses are `rsp_sum`=0,2,4,6 with matching `rsp_id`.
- **Backpressure:** `rsp_ready`=0 for 5 cycles during RESP. `rsp_valid`, `rsp_sum` and `rsp_id` stay stable, and no `req_ready` is asserted until the cycle after `rsp_ready`=1.
- **Boundary sum:** requester 0 sends A=15, B=15, giving `rsp_sum`=30 (5'b11110). A=0, B=0 gives `rsp_sum`=0.
- **Reset mid-operation:** assert `rst` in the CAPTURE cycle. Outputs clear immediately with no `rsp_valid`. After release, a pending request from requester 1 is granted first (priority restarts at 0, and 0 is idle).

Source files
------------

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Round-robin scheduler in front of one shared registered adder. One operand
//   pair is accepted at a time from N_REQ requesters over a valid/ready
//   handshake. The operands are driven to the adder with a one-cycle load
//   enable. The registered sum is captured and returned, tagged with the
//   requester index, over a valid/ready response channel.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  [N_REQ]     per-requester request valid
//   req_ready  [N_REQ]     per-requester accept (one-hot or zero, IDLE only)
//   req_a      [N_REQ*W]   packed operand A, requester i at [i*W +: W]
//   req_b      [N_REQ*W]   packed operand B, same packing
//   add_a      [W]         operand A to the shared adder (registered)
//   add_b      [W]         operand B to the shared adder (registered)
//   add_en     1           adder load enable (registered, one cycle)
//   add_sum    [W+1]       registered sum returned by the adder
//   rsp_valid  1           result valid
//   rsp_ready  1           result consumer ready
//   rsp_sum    [W+1]       result
//   rsp_id     [IDW]       requester index owning rsp_sum
// -----------------------------------------------------------------------------
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    output logic               add_en,
    input  logic [W:0]         add_sum,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W:0]         rsp_sum,
    output logic [IDW-1:0]     rsp_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [IDW-1:0]     last_gnt_q;
    logic [IDW-1:0]     gnt_id_q;
    logic [W-1:0]       add_a_q;
    logic [W-1:0]       add_b_q;
    logic               add_en_q;
    logic               rsp_valid_q;
    logic [W:0]         rsp_sum_q;
    logic [IDW-1:0]     rsp_id_q;

    logic               win_found_s;
    logic [IDW-1:0]     win_id_s;
    logic               accept_s;
    logic [N_REQ-1:0]   req_ready_s;
    logic [W-1:0]       win_a_s;
    logic [W-1:0]       win_b_s;

    // Round-robin search: start one past the last winner, first valid wins.
    always_comb begin
        logic [IDW-1:0] cand_v;
        cand_v      = '0;
        win_found_s = 1'b0;
        win_id_s    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_v = IDW'((int'(last_gnt_q) + k) % N_REQ);
            if (!win_found_s && req_valid[cand_v]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_v;
            end else begin
                win_found_s = win_found_s;
                win_id_s    = win_id_s;
            end
        end
    end

    // Operand mux for the current grant winner.
    always_comb begin
        win_a_s = req_a[int'(win_id_s)*W +: W];
        win_b_s = req_b[int'(win_id_s)*W +: W];
    end

    // Next-state logic; an accept can only happen in IDLE.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d  = ST_ISSUE;
                    accept_s = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Combinational accept, held low while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        if (accept_s && !rst) begin
            req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_id_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // State register plus registered strobes derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            add_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            add_en_q    <= (state_d == ST_ISSUE);
            rsp_valid_q <= (state_d == ST_RESP);
        end
    end

    // Grant bookkeeping and operand registers, loaded on accept only.
    // last_gnt resets to N_REQ-1 so requester 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= IDW'(N_REQ - 1);
            gnt_id_q   <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
        end else if (accept_s) begin
            last_gnt_q <= win_id_s;
            gnt_id_q   <= win_id_s;
            add_a_q    <= win_a_s;
            add_b_q    <= win_b_s;
        end
    end

    // Response capture: the adder sum is valid during CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_sum_q <= '0;
            rsp_id_q  <= '0;
        end else if (state_q == ST_CAPTURE) begin
            rsp_sum_q <= add_sum;
            rsp_id_q  <= gnt_id_q;
        end
    end

    assign req_ready = req_ready_s;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_en    = add_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//   Directed bench for adder_arbiter with a behavioural registered 4-bit adder
//   (load on enable, async reset) standing in for the shared adder instance.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_en;
    logic [4:0]  add_sum;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_sum;
    logic [1:0]  rsp_id;

    int n_cmp;
    int n_err;

    adder_arbiter #(.N_REQ(4), .W(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_en    (add_en),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared adder model: registered sum, loads on enable, async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_sum <= 5'd0;
        end else if (add_en) begin
            add_sum <= {1'b0, add_a} + {1'b0, add_b};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated request; entered at edge+1 of an IDLE cycle, returns at
    // edge+1 of the following IDLE cycle.
    task automatic run_single(input string tag, input int id, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] exp_rdy,
                              input logic [4:0] exp_sum, input logic [1:0] exp_id);
        req_a              = 16'd0;
        req_b              = 16'd0;
        req_a[id*4 +: 4]   = a;
        req_b[id*4 +: 4]   = b;
        req_valid          = exp_rdy;
        rsp_ready          = 1'b1;
        #1;
        check_eq({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        check_eq({tag, "_en_idle"}, 32'(add_en), 32'd0);
        step();
        req_valid = 4'd0;
        #1;
        check_eq({tag, "_en_issue"}, 32'(add_en), 32'd1);
        check_eq({tag, "_add_a"}, 32'(add_a), 32'(a));
        check_eq({tag, "_add_b"}, 32'(add_b), 32'(b));
        step();
        #1;
        check_eq({tag, "_en_capt"}, 32'(add_en), 32'd0);
        check_eq({tag, "_vld_capt"}, 32'(rsp_valid), 32'd0);
        step();
        #1;
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_rsp_sum"}, 32'(rsp_sum), 32'(exp_sum));
        check_eq({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
        step();
    endtask

    // Hand-computed contention expectations: grants 0,1,2,3,0 on operands i+i.
    logic [3:0] cont_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [4:0] cont_sum [5] = '{5'd0, 5'd2, 5'd4, 5'd6, 5'd0};
    logic [1:0] cont_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = 4'd0;
        req_a     = 16'd0;
        req_b     = 16'd0;
        rsp_ready = 1'b1;

        // ---------------- reset values ----------------
        step();
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_add_a", 32'(add_a), 32'd0);
        check_eq("rst_add_b", 32'(add_b), 32'd0);
        check_eq("rst_add_en", 32'(add_en), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("idle_add_en", 32'(add_en), 32'd0);
            check_eq("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("idle_req_ready", 32'(req_ready), 32'd0);
            step();
        end

        // ---------------- full contention ----------------
        req_valid = 4'b1111;
        req_a     = {4'd3, 4'd2, 4'd1, 4'd0};
        req_b     = {4'd3, 4'd2, 4'd1, 4'd0};
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            check_eq("cont_ready", 32'(req_ready), 32'(cont_rdy[g]));
            step();
            if (g == 4) req_valid = 4'd0;
            #1;
            check_eq("cont_en", 32'(add_en), 32'd1);
            check_eq("cont_ready_busy", 32'(req_ready), 32'd0);
            step();
            step();
            #1;
            check_eq("cont_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("cont_rsp_sum", 32'(rsp_sum), 32'(cont_sum[g]));
            check_eq("cont_rsp_id", 32'(rsp_id), 32'(cont_id[g]));
            step();
        end

        // ---------------- single request ----------------
        run_single("single", 2, 4'd3, 4'd5, 4'b0100, 5'd8, 2'd2);

        // ---------------- backpressure ----------------
        req_a          = 16'd0;
        req_b          = 16'd0;
        req_a[15:12]   = 4'd7;
        req_b[15:12]   = 4'd6;
        req_valid      = 4'b1000;
        rsp_ready      = 1'b0;
        #1;
        check_eq("bp_ready3", 32'(req_ready), 32'b1000);
        step();
        req_valid    = 4'b0010;
        req_a[7:4]   = 4'd1;
        req_b[7:4]   = 4'd2;
        #1;
        check_eq("bp_ready_issue", 32'(req_ready), 32'd0);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_rsp_sum", 32'(rsp_sum), 32'd13);
            check_eq("bp_rsp_id", 32'(rsp_id), 32'd3);
            check_eq("bp_ready_hold", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_rsp_valid_hs", 32'(rsp_valid), 32'd1);
        check_eq("bp_no_bypass", 32'(req_ready), 32'd0);
        step();
        #1;
        check_eq("bp_rsp_valid_idle", 32'(rsp_valid), 32'd0);
        check_eq("bp_ready1", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'd0;
        #1;
        check_eq("bp_add_a1", 32'(add_a), 32'd1);
        step();
        step();
        #1;
        check_eq("bp_rsp_sum1", 32'(rsp_sum), 32'd3);
        check_eq("bp_rsp_id1", 32'(rsp_id), 32'd1);
        step();

        // ---------------- boundary sums ----------------
        run_single("max", 0, 4'd15, 4'd15, 4'b0001, 5'b11110, 2'd0);
        run_single("zero", 0, 4'd0, 4'd0, 4'b0001, 5'd0, 2'd0);

        // ---------------- reset mid-operation ----------------
        req_a          = 16'd0;
        req_b          = 16'd0;
        req_a[15:12]   = 4'd2;
        req_b[15:12]   = 4'd2;
        req_valid      = 4'b1000;
        #1;
        check_eq("mr_ready3", 32'(req_ready), 32'b1000);
        step();
        req_valid  = 4'b0010;
        req_a[7:4] = 4'd4;
        req_b[7:4] = 4'd9;
        step();
        rst = 1'b1;
        #1;
        check_eq("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mr_add_en", 32'(add_en), 32'd0);
        check_eq("mr_add_a", 32'(add_a), 32'd0);
        check_eq("mr_add_b", 32'(add_b), 32'd0);
        check_eq("mr_rsp_sum", 32'(rsp_sum), 32'd0);
        check_eq("mr_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("mr_req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_eq("mr_ready1", 32'(req_ready), 32'b0010);
        check_eq("mr_rsp_valid_idle", 32'(rsp_valid), 32'd0);
        step();
        req_valid = 4'd0;
        #1;
        check_eq("mr_en", 32'(add_en), 32'd1);
        check_eq("mr_add_a1", 32'(add_a), 32'd4);
        step();
        step();
        #1;
        check_eq("mr_rsp_valid1", 32'(rsp_valid), 32'd1);
        check_eq("mr_rsp_sum1", 32'(rsp_sum), 32'd13);
        check_eq("mr_rsp_id1", 32'(rsp_id), 32'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
